// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helper for the IF/DM memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  localparam int TIMEOUT_DEFAULT = 15;

  // Bits needed to hold a counter that reaches max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arb_priority.sv
// Grant selection between IF and DM, with a streak limit so a steady DM load
// stream cannot starve instruction fetch indefinitely.
module mem_arb_priority
  import mem_arb_pkg::*;
#(
  parameter int DM_STREAK = 4
) (
  input  logic   clk_i,
  input  logic   rst_n_i,
  input  logic   if_req_i,
  input  logic   dm_req_i,
  input  logic   arb_en_i,
  output logic   gnt_valid_o,
  output owner_e gnt_owner_o
);

  localparam int            SW         = cnt_width(DM_STREAK);
  localparam logic [SW-1:0] STREAK_MAX = SW'(DM_STREAK);

  logic [SW-1:0] streak_q, streak_d;
  logic          if_starved_s;

  // DM wins by default; IF wins once DM has used up its streak while IF waits.
  always_comb begin
    if_starved_s = (streak_q == STREAK_MAX) && if_req_i;
    gnt_valid_o  = 1'b0;
    gnt_owner_o  = OWN_IF;
    if (arb_en_i && dm_req_i && !if_starved_s) begin
      gnt_valid_o = 1'b1;
      gnt_owner_o = OWN_DM;
    end else if (arb_en_i && if_req_i) begin
      gnt_valid_o = 1'b1;
      gnt_owner_o = OWN_IF;
    end else begin
      gnt_valid_o = 1'b0;
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (!if_req_i) begin
      streak_d = {SW{1'b0}};
    end else if (gnt_valid_o && (gnt_owner_o == OWN_IF)) begin
      streak_d = {SW{1'b0}};
    end else if (gnt_valid_o && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + SW'(1'b1);
    end else begin
      streak_d = streak_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) streak_q <= {SW{1'b0}};
    else          streak_q <= streak_d;
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares one word-addressed RAM port between instruction fetch and data access:
// grant, drive RAM from latched operands, wait for MFC (or time out), ack, release.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = TIMEOUT_DEFAULT,
  parameter int DM_STREAK = 4
) (
  input  logic              Clock,
  input  logic              Reset_L,
  input  logic              IF_Req,
  input  logic [ADDR_W-1:0] IF_Address,
  output logic              IF_Ack,
  output logic [DATA_W-1:0] IF_Data_Out,
  input  logic              DM_Req,
  input  logic              DM_Read_H_Write_L,
  input  logic [ADDR_W-1:0] DM_Address,
  input  logic [DATA_W-1:0] DM_Data_In,
  output logic              DM_Ack,
  output logic [DATA_W-1:0] DM_Data_Out,
  output logic              Bus_Error,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic              Mem_Read_H_Write_L,
  output logic [DATA_W-1:0] Mem_Data_In,
  input  logic [DATA_W-1:0] Mem_Data_Out,
  input  logic              Mem_MFC
);

  localparam int            TW         = cnt_width(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              if_ack_q, if_ack_d, dm_ack_q, dm_ack_d, berr_q, berr_d;
  logic [DATA_W-1:0] if_dout_q, if_dout_d, dm_dout_q, dm_dout_d;
  logic [DATA_W-1:0] resp_data_s;
  logic              gnt_valid_s;
  owner_e            gnt_owner_s;

  mem_arb_priority #(.DM_STREAK(DM_STREAK)) u_priority (
    .clk_i       (Clock),
    .rst_n_i     (Reset_L),
    .if_req_i    (IF_Req),
    .dm_req_i    (DM_Req),
    .arb_en_i    (state_q == IDLE),
    .gnt_valid_o (gnt_valid_s),
    .gnt_owner_o (gnt_owner_s)
  );

  // Next-state, operand latching and response generation.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    wdata_d     = wdata_q;
    timer_d     = timer_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    berr_d      = 1'b0;
    if_dout_d   = if_dout_q;
    dm_dout_d   = dm_dout_q;
    resp_data_s = Mem_MFC ? Mem_Data_Out : {DATA_W{1'b0}};
    case (state_q)
      IDLE: begin
        if (gnt_valid_s) begin
          state_d = ACCESS;
          owner_d = gnt_owner_s;
          timer_d = {TW{1'b0}};
          if (gnt_owner_s == OWN_DM) begin
            addr_d  = DM_Address;
            rw_d    = DM_Read_H_Write_L;
            wdata_d = DM_Data_In;
          end else begin
            addr_d  = IF_Address;
            rw_d    = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        // MFC takes precedence over a timeout landing in the same cycle.
        if (Mem_MFC || (timer_q == TIMER_LAST)) begin
          state_d = RESPOND;
          rw_d    = 1'b1;
          berr_d  = !Mem_MFC;
          if (owner_q == OWN_DM) begin
            dm_ack_d  = 1'b1;
            dm_dout_d = resp_data_s;
          end else begin
            if_ack_d  = 1'b1;
            if_dout_d = resp_data_s;
          end
        end else begin
          timer_d = timer_q + TW'(1'b1);
        end
      end
      RESPOND: state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset mid-access aborts without an ack.
  always_ff @(posedge Clock) begin
    if (!Reset_L) begin
      state_q   <= IDLE;
      owner_q   <= OWN_IF;
      addr_q    <= {ADDR_W{1'b0}};
      rw_q      <= 1'b1;
      wdata_q   <= {DATA_W{1'b0}};
      timer_q   <= {TW{1'b0}};
      if_ack_q  <= 1'b0;
      dm_ack_q  <= 1'b0;
      berr_q    <= 1'b0;
      if_dout_q <= {DATA_W{1'b0}};
      dm_dout_q <= {DATA_W{1'b0}};
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      wdata_q   <= wdata_d;
      timer_q   <= timer_d;
      if_ack_q  <= if_ack_d;
      dm_ack_q  <= dm_ack_d;
      berr_q    <= berr_d;
      if_dout_q <= if_dout_d;
      dm_dout_q <= dm_dout_d;
    end
  end

  assign IF_Ack             = if_ack_q;
  assign IF_Data_Out        = if_dout_q;
  assign DM_Ack             = dm_ack_q;
  assign DM_Data_Out        = dm_dout_q;
  assign Bus_Error          = berr_q;
  assign Mem_Address        = addr_q;
  assign Mem_Read_H_Write_L = rw_q;
  assign Mem_Data_In        = wdata_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Scoreboard bench: stimulus pushes expected acks, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_mem_access_arbiter;

  logic        Clock = 1'b0;
  logic        Reset_L = 1'b0;
  logic        IF_Req = 1'b0;
  logic [31:0] IF_Address = 32'h0;
  logic        IF_Ack;
  logic [31:0] IF_Data_Out;
  logic        DM_Req = 1'b0;
  logic        DM_Read_H_Write_L = 1'b1;
  logic [31:0] DM_Address = 32'h0;
  logic [31:0] DM_Data_In = 32'h0;
  logic        DM_Ack;
  logic [31:0] DM_Data_Out;
  logic        Bus_Error;
  logic [31:0] Mem_Address;
  logic        Mem_Read_H_Write_L;
  logic [31:0] Mem_Data_In;
  logic [31:0] Mem_Data_Out;
  logic        Mem_MFC;

  logic        mfc_en = 1'b1;
  logic        ram_clear = 1'b1;
  logic [31:0] ram [0:255];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          wr_low_cnt = 0;

  typedef struct {
    bit          dm;
    bit          err;
    bit          chk_data;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] mon_data;

  always #5 Clock = ~Clock;

  mem_access_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(15), .DM_STREAK(4)
  ) dut (
    .Clock              (Clock),
    .Reset_L            (Reset_L),
    .IF_Req             (IF_Req),
    .IF_Address         (IF_Address),
    .IF_Ack             (IF_Ack),
    .IF_Data_Out        (IF_Data_Out),
    .DM_Req             (DM_Req),
    .DM_Read_H_Write_L  (DM_Read_H_Write_L),
    .DM_Address         (DM_Address),
    .DM_Data_In         (DM_Data_In),
    .DM_Ack             (DM_Ack),
    .DM_Data_Out        (DM_Data_Out),
    .Bus_Error          (Bus_Error),
    .Mem_Address        (Mem_Address),
    .Mem_Read_H_Write_L (Mem_Read_H_Write_L),
    .Mem_Data_In        (Mem_Data_In),
    .Mem_Data_Out       (Mem_Data_Out),
    .Mem_MFC            (Mem_MFC)
  );

  function automatic logic [31:0] ram_init(input int i);
    if (i == 16) return 32'hDEADBEEF;
    return 32'hC0DE0000 | 32'(i);
  endfunction

  // Zero-wait RAM model: MFC is a level the bench controls.
  assign Mem_MFC      = mfc_en;
  assign Mem_Data_Out = ram[Mem_Address[7:0]];

  always @(posedge Clock) begin
    if (ram_clear) begin
      for (int i = 0; i < 256; i++) ram[i] <= ram_init(i);
    end else if (Mem_MFC && !Mem_Read_H_Write_L) begin
      ram[Mem_Address[7:0]] <= Mem_Data_In;
    end
  end

  always @(posedge Clock) cyc <= cyc + 1;

  // Monitor: every ack must match the next expected response.
  always @(negedge Clock) begin
    if (Reset_L && !Mem_Read_H_Write_L) wr_low_cnt <= wr_low_cnt + 1;
    if (IF_Ack || DM_Ack) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ack cyc=%0d if_ack=%0b dm_ack=%0b", cyc, IF_Ack, DM_Ack);
      end else begin
        mon_e    = exp_q.pop_front();
        mon_data = DM_Ack ? DM_Data_Out : IF_Data_Out;
        if ((IF_Ack && DM_Ack) || (DM_Ack != mon_e.dm) || (Bus_Error != mon_e.err) ||
            (mon_e.chk_data && (mon_data !== mon_e.data)) ||
            ((mon_e.cyc >= 0) && (cyc != mon_e.cyc))) begin
          failures++;
          $display("FAIL ack_compare got: if_ack=%0b dm_ack=%0b err=%0b data=%h cyc=%0d; want: dm=%0b err=%0b data=%h cyc=%0d",
                   IF_Ack, DM_Ack, Bus_Error, mon_data, cyc, mon_e.dm, mon_e.err, mon_e.data, mon_e.cyc);
        end
      end
    end else if (Bus_Error) begin
      checks++;
      failures++;
      $display("FAIL bus_error_without_ack cyc=%0d", cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic push_exp(input bit dm, input bit err, input bit chk_d, input logic [31:0] d, input int c);
    exp_t e;
    e.dm = dm; e.err = err; e.chk_data = chk_d; e.data = d; e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Waits (bounded) for the requester's ack, returns #1 after the following edge.
  task automatic wait_ack(input bit dm);
    bit seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge Clock);
      seen = dm ? DM_Ack : IF_Ack;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL ack_wait_expired dm=%0b got=no_ack want=ack", dm);
    end
    @(posedge Clock); #1;
  endtask

  task automatic if_read(input logic [31:0] a, input logic [31:0] want, input bit err, input int lat);
    push_exp(1'b0, err, 1'b1, want, cyc + lat);
    IF_Address = a;
    IF_Req = 1'b1;
    wait_ack(1'b0);
    IF_Req = 1'b0;
    @(posedge Clock); #1;
  endtask

  task automatic dm_op(input bit rd, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] want, input bit chk_d, input int lat);
    push_exp(1'b1, 1'b0, chk_d, want, cyc + lat);
    DM_Read_H_Write_L = rd;
    DM_Address = a;
    DM_Data_In = wd;
    DM_Req = 1'b1;
    wait_ack(1'b1);
    DM_Req = 1'b0;
    DM_Read_H_Write_L = 1'b1;
    @(posedge Clock); #1;
  endtask

  initial begin
    int wl0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    chk("rst_if_ack", 32'(IF_Ack), 32'h0);
    chk("rst_dm_ack", 32'(DM_Ack), 32'h0);
    chk("rst_bus_error", 32'(Bus_Error), 32'h0);
    chk("rst_read_w", 32'(Mem_Read_H_Write_L), 32'h1);
    chk("rst_mem_addr", Mem_Address, 32'h0);
    chk("rst_mem_data_in", Mem_Data_In, 32'h0);
    chk("rst_if_data", IF_Data_Out, 32'h0);
    chk("rst_dm_data", DM_Data_Out, 32'h0);
    @(posedge Clock); #1;
    Reset_L = 1'b1;
    ram_clear = 1'b0;

    // Minimum-latency fetch.
    if_read(32'h10, 32'hDEADBEEF, 1'b0, 2);

    // Store then load back; read_w low for exactly the one ACCESS cycle.
    wl0 = wr_low_cnt;
    dm_op(1'b0, 32'h20, 32'hA5A5A5A5, 32'h0, 1'b0, 2);
    chk("store_read_w_low_cycles", 32'(wr_low_cnt - wl0), 32'h1);
    dm_op(1'b1, 32'h20, 32'h0, 32'hA5A5A5A5, 1'b1, 2);

    // Both requesting continuously: DM x4, then IF, then DM.
    for (int i = 0; i < 4; i++) push_exp(1'b1, 1'b0, 1'b1, ram_init(32'h40 + i), -1);
    push_exp(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, -1);
    push_exp(1'b1, 1'b0, 1'b1, ram_init(32'h44), -1);
    fork
      begin
        IF_Address = 32'h10;
        IF_Req = 1'b1;
        wait_ack(1'b0);
        IF_Req = 1'b0;
      end
      begin
        for (int i = 0; i < 5; i++) begin
          DM_Address = 32'h40 + 32'(i);
          DM_Read_H_Write_L = 1'b1;
          DM_Req = 1'b1;
          wait_ack(1'b1);
        end
        DM_Req = 1'b0;
      end
    join
    @(posedge Clock); #1;

    // MFC never comes: ack with bus error 16 cycles after the grant edge.
    mfc_en = 1'b0;
    if_read(32'h30, 32'h0, 1'b1, 17);
    mfc_en = 1'b1;

    // Operands change and request drops after grant; latched copies must be used.
    mfc_en = 1'b0;
    push_exp(1'b1, 1'b0, 1'b1, ram_init(32'h50), cyc + 4);
    DM_Address = 32'h50;
    DM_Read_H_Write_L = 1'b1;
    DM_Req = 1'b1;
    @(posedge Clock); #1;
    DM_Req = 1'b0;
    DM_Address = 32'h99;
    DM_Read_H_Write_L = 1'b0;
    DM_Data_In = 32'hFFFF0000;
    @(negedge Clock);
    chk("late_change_mem_addr", Mem_Address, 32'h50);
    chk("late_change_read_w", 32'(Mem_Read_H_Write_L), 32'h1);
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    mfc_en = 1'b1;
    wait_ack(1'b1);
    DM_Read_H_Write_L = 1'b1;
    @(posedge Clock); #1;

    // Reset held 3 cycles in the middle of a store ACCESS.
    mfc_en = 1'b0;
    DM_Address = 32'h60;
    DM_Data_In = 32'h12345678;
    DM_Read_H_Write_L = 1'b0;
    DM_Req = 1'b1;
    @(posedge Clock); #1;
    @(negedge Clock);
    chk("abort_store_read_w_low", 32'(Mem_Read_H_Write_L), 32'h0);
    @(posedge Clock); #1;
    Reset_L = 1'b0;
    DM_Req = 1'b0;
    DM_Read_H_Write_L = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    chk("abort_read_w", 32'(Mem_Read_H_Write_L), 32'h1);
    chk("abort_mem_addr", Mem_Address, 32'h0);
    chk("abort_mem_data_in", Mem_Data_In, 32'h0);
    @(posedge Clock);
    @(posedge Clock); #1;
    Reset_L = 1'b1;
    mfc_en = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    if_read(32'h10, 32'hDEADBEEF, 1'b0, 2);
    dm_op(1'b1, 32'h60, 32'h0, ram_init(32'h60), 1'b1, 2);

    repeat (3) @(posedge Clock);
    @(negedge Clock);
    chk("pending_expected_acks", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
